// File: rtl/mdc_fft_pkg.sv
// mdc_fft_pkg: shared state type and elaboration-time helpers for the
// radix-2 MDC FFT sequencer (stage start times, output latency, bit reversal).
package mdc_fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Advance index at which stage s first sees valid data:
    // N - B_s plus the butterfly pipeline registers of the earlier stages.
    function automatic int stage_start(input int s, input int log2n, input int bf_lat);
        int n;
        n = 1 << log2n;
        return n - (n >> (s + 1)) + s * bf_lat;
    endfunction

    // Advance index of the first output pair (last stage start plus its own latency).
    function automatic int t_out(input int log2n, input int bf_lat);
        return stage_start(log2n - 1, log2n, bf_lat) + bf_lat;
    endfunction

    // Reverse the low log2n bits of x (log2n <= 10).
    function automatic logic [9:0] bitrev(input logic [9:0] x, input int log2n);
        logic [9:0] r;
        r = {<<{x}};
        return r >> (10 - log2n);
    endfunction

endpackage

// File: rtl/mdc_stage_seq.sv
// mdc_stage_seq: sequencing for one butterfly stage S of the MDC pipeline.
// Arms the stage enable when the global advance index reaches the stage start,
// then runs a wrapping local counter that drives the twiddle address lane and
// the commutator select following this stage.
module mdc_stage_seq
    import mdc_fft_pkg::*;
#(
    parameter int LOG2N  = 5,
    parameter int BF_LAT = 0,
    parameter int S      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ce,
    input  logic             i_clr,
    input  logic [LOG2N+1:0] i_k,
    output logic             o_stage_en,
    output logic             o_com_sel,
    output logic [LOG2N-2:0] o_tw_addr
);

    localparam int KW = LOG2N + 2;
    localparam int TS = stage_start(S, LOG2N, BF_LAT);
    localparam int BS = (1 << LOG2N) >> (S + 1);
    // The enable is set by the ce that moves k from TS-1 to TS.
    localparam logic [KW-1:0]    K_ARM     = KW'(TS - 1);
    localparam logic [LOG2N-1:0] LANE_MASK = LOG2N'(BS - 1);

    logic             r_en;
    logic [LOG2N-1:0] r_lcnt;
    logic [LOG2N-1:0] w_lane;

    // Sticky enable and local counter (k - TS) mod N; both cleared at drain end.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_en   <= 1'b0;
            r_lcnt <= '0;
        end else if (i_ce) begin
            if (r_en) begin
                r_lcnt <= r_lcnt + LOG2N'(1);
            end
            if (i_k == K_ARM) begin
                r_en <= 1'b1;
            end
        end
    end

    assign w_lane     = r_lcnt & LANE_MASK;
    assign o_stage_en = r_en;
    // Twiddle step for stage S is 2^S, so lane value is (lcnt mod B_s) << S.
    assign o_tw_addr  = r_en ? (LOG2N-1)'(w_lane << S) : '0;

    generate
        if (S < LOG2N - 1) begin : g_com
            // Toggles every B_(S+1) advances.
            assign o_com_sel = r_en & r_lcnt[LOG2N-2-S];
        end else begin : g_no_com
            assign o_com_sel = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mdc_fft_ctrl.sv
// mdc_fft_ctrl: control sequencer for an N = 2^LOG2N point radix-2 MDC FFT.
// Produces the advance strobe, per-stage enables, commutator selects, twiddle
// addresses and output valid/index/frame_done. FLUSH drains the last frame.
// Valid/ready: a sample pair transfers on a cycle where in_valid and in_ready
// are both 1; in_ready is 0 only while draining, when in_valid is ignored.
// Build option: BITREV_ADDR_EN makes out_idx the bit-reversed output count
// (natural frequency bin); otherwise out_idx is the arrival order.
module mdc_fft_ctrl
    import mdc_fft_pkg::*;
#(
    parameter int LOG2N  = 5,
    parameter int BF_LAT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       ce,
    output logic                       busy,
    output logic [LOG2N-1:0]           stage_en,
    output logic [LOG2N-2:0]           com_sel,
    output logic [LOG2N*(LOG2N-1)-1:0] tw_addr,
    output logic                       out_valid,
    output logic [LOG2N-1:0]           out_idx,
    output logic                       frame_done
);

    localparam int N       = 1 << LOG2N;
    localparam int KW      = LOG2N + 2;
    localparam int T_OUT_I = t_out(LOG2N, BF_LAT);
    localparam logic [KW-1:0]    K_OUT  = KW'(T_OUT_I);
    localparam logic [KW-1:0]    F_LAST = KW'(T_OUT_I - 1);
    localparam logic [LOG2N-1:0] O_LAST = LOG2N'(N - 1);

    state_t           r_state;
    state_t           w_next;
    logic [KW-1:0]    r_k;
    logic [KW-1:0]    r_fcnt;
    logic [LOG2N-1:0] r_ipos;
    logic [LOG2N-1:0] r_ocnt;
    logic             w_accept;
    logic             w_ce;
    logic             w_drain_done;
    logic             w_out_valid;

    assign in_ready     = rst | (r_state != FLUSH);
    assign w_accept     = in_valid & (r_state != FLUSH);
    assign w_ce         = ~rst & (w_accept | (r_state == FLUSH));
    assign w_drain_done = w_ce & (r_state == FLUSH) & (r_fcnt == F_LAST);
    assign w_out_valid  = w_ce & (r_k >= K_OUT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: flush is honoured only on an idle input cycle at a frame boundary.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = RUN;
            RUN:     if (!in_valid && flush && (r_ipos == '0)) w_next = FLUSH;
            FLUSH:   if (w_drain_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Advance index (saturating), input position, drain length and output count.
    always_ff @(posedge clk) begin
        if (rst || w_drain_done) begin
            r_k    <= '0;
            r_ipos <= '0;
            r_fcnt <= '0;
            r_ocnt <= '0;
        end else begin
            if (w_ce && (r_k != K_OUT)) r_k <= r_k + KW'(1);
            if (w_ce && (r_state != FLUSH)) r_ipos <= r_ipos + LOG2N'(1);
            if (w_ce && (r_state == FLUSH)) r_fcnt <= r_fcnt + KW'(1);
            if (w_out_valid) r_ocnt <= r_ocnt + LOG2N'(1);
        end
    end

    assign ce         = w_ce;
    assign busy       = (r_state != IDLE);
    assign out_valid  = w_out_valid;
    assign frame_done = w_out_valid & (r_ocnt == O_LAST);

`ifdef BITREV_ADDR_EN
    assign out_idx = LOG2N'(bitrev(10'(r_ocnt), LOG2N));
`else
    assign out_idx = r_ocnt;
`endif

    generate
        for (genvar s = 0; s < LOG2N; s++) begin : g_stage
            logic w_cs;
            mdc_stage_seq #(
                .LOG2N (LOG2N),
                .BF_LAT(BF_LAT),
                .S     (s)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .i_ce      (w_ce),
                .i_clr     (w_drain_done),
                .i_k       (r_k),
                .o_stage_en(stage_en[s]),
                .o_com_sel (w_cs),
                .o_tw_addr (tw_addr[s*(LOG2N-1) +: LOG2N-1])
            );
            if (s < LOG2N - 1) begin : g_cs
                assign com_sel[s] = w_cs;
            end else begin : g_last
                logic w_cs_unused;
                assign w_cs_unused = w_cs;
            end
        end
    endgenerate

endmodule

// File: tb/tb_mdc_fft_ctrl.sv
// tb_mdc_fft_ctrl: directed bench for mdc_fft_ctrl (N=32) with a scoreboard.
// Two instances: BF_LAT=0 and BF_LAT=2; sel2 routes stimulus and checking.
`timescale 1ns/1ps
module tb_mdc_fft_ctrl;

    localparam int L  = 5;
    localparam int N  = 32;
    localparam int VW = 36;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic in_valid = 1'b0;
    logic flush    = 1'b0;
    logic sel2     = 1'b0;

    logic v0, f0, v2, f2;
    assign v0 = in_valid & ~sel2;
    assign f0 = flush & ~sel2;
    assign v2 = in_valid & sel2;
    assign f2 = flush & sel2;

    logic        rdy0, ce0, busy0, ov0, fd0;
    logic [4:0]  en0, idx0;
    logic [3:0]  cs0;
    logic [19:0] tw0;
    logic        rdy2, ce2, busy2, ov2, fd2;
    logic [4:0]  en2, idx2;
    logic [3:0]  cs2;
    logic [19:0] tw2;

    mdc_fft_ctrl #(.LOG2N(5), .BF_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .flush(f0),
        .ce(ce0), .busy(busy0), .stage_en(en0), .com_sel(cs0), .tw_addr(tw0),
        .out_valid(ov0), .out_idx(idx0), .frame_done(fd0)
    );

    mdc_fft_ctrl #(.LOG2N(5), .BF_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .flush(f2),
        .ce(ce2), .busy(busy2), .stage_en(en2), .com_sel(cs2), .tw_addr(tw2),
        .out_valid(ov2), .out_idx(idx2), .frame_done(fd2)
    );

    logic          d_ce, d_rdy, d_busy, d_ov, d_fd;
    logic [4:0]    d_en, d_idx;
    logic [3:0]    d_cs;
    logic [19:0]   d_tw;
    logic [VW-1:0] d_vec;

    always_comb begin
        d_ce   = sel2 ? ce2   : ce0;
        d_rdy  = sel2 ? rdy2  : rdy0;
        d_busy = sel2 ? busy2 : busy0;
        d_ov   = sel2 ? ov2   : ov0;
        d_fd   = sel2 ? fd2   : fd0;
        d_en   = sel2 ? en2   : en0;
        d_idx  = sel2 ? idx2  : idx0;
        d_cs   = sel2 ? cs2   : cs0;
        d_tw   = sel2 ? tw2   : tw0;
        d_vec  = {d_en, d_cs, d_tw, d_ov, d_idx, d_fd};
    end

    // ---------------- checking infrastructure ----------------
    int n_chk  = 0;
    int n_pass = 0;
    int fd_seen = 0;
    logic [VW-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [4:0] rev5(input logic [4:0] v);
        logic [4:0] r;
        r = {<<{v}};
        return r;
    endfunction

    function automatic int tout_of(input int b);
        return N - 1 + (L - 1) * b + b;
    endfunction

    // Expected output vector for advance index k, straight from the stage timing formulas.
    function automatic logic [VW-1:0] model_vec(input int k, input bit cev, input int b);
        logic [4:0]  en;
        logic [3:0]  cs;
        logic [19:0] tw;
        logic        ov, fd;
        logic [4:0]  idx;
        int ts, l, oc, tout;
        en = '0; cs = '0; tw = '0;
        tout = tout_of(b);
        for (int s = 0; s < L; s++) begin
            ts = N - (N >> (s + 1)) + s * b;
            if (k >= ts) begin
                en = en | 5'(1 << s);
                l  = (k - ts) % N;
                tw = tw | 20'(((l % (N >> (s + 1))) << s) << (s * 4));
                if (s < L - 1) cs = cs | 4'(((l >> (L - 2 - s)) & 1) << s);
            end
        end
        ov = cev && (k >= tout);
        oc = (k >= tout) ? (k - tout) % N : 0;
`ifdef BITREV_ADDR_EN
        idx = rev5(5'(oc));
`else
        idx = 5'(oc);
`endif
        fd = ov && (oc == N - 1);
        return {en, cs, tw, ov, idx, fd};
    endfunction

    // Model state and per-cycle expectations (written by driver tasks only).
    int m_state = 0;  // 0 idle, 1 run, 2 flush
    int kk = 0, ipos = 0, fcnt = 0, bl = 0;
    bit chk_en = 1'b0;
    bit e_ce = 1'b0, e_rdy = 1'b1, e_busy = 1'b0;
    logic [VW-1:0] e_vec = '0;

    // ---------------- driver tasks ----------------
    task automatic step(input bit v, input bit f);
        @(posedge clk); #1;
        in_valid = v;
        flush    = f;
        e_rdy  = (m_state != 2);
        e_busy = (m_state != 0);
        e_ce   = (m_state == 2) || v;
        e_vec  = model_vec(kk, e_ce, bl);
        if (e_ce) exp_q.push_back(e_vec);
        case (m_state)
            0: if (v) begin m_state = 1; kk = 1; ipos = 1; end
            1: begin
                if (v) begin kk++; ipos = (ipos + 1) % N; end
                else if (f && ipos == 0) begin m_state = 2; fcnt = 0; end
            end
            default: begin
                kk++; fcnt++;
                if (fcnt == tout_of(bl)) begin m_state = 0; kk = 0; ipos = 0; end
            end
        endcase
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        chk_en = 1'b0; rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("rst_ce", d_ce, 0);
        chk("rst_in_ready", d_rdy, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        m_state = 0; kk = 0; ipos = 0; fcnt = 0;
        e_ce = 1'b0; e_rdy = 1'b1; e_busy = 1'b0;
        e_vec = model_vec(0, 1'b0, bl);
        chk_en = 1'b1;
        @(negedge clk);
        chk("post_rst_outputs", d_vec, '0);
        chk("post_rst_busy", d_busy, 0);
    endtask

    task automatic spot(input string nm, input logic [4:0] en, input logic [3:0] cs,
                        input logic [19:0] tw, input logic ov);
        @(negedge clk);
        chk({nm, "_stage_en"}, d_en, en);
        chk({nm, "_com_sel"}, d_cs, cs);
        chk({nm, "_tw_addr"}, d_tw, tw);
        chk({nm, "_out_valid"}, d_ov, ov);
    endtask

    task automatic drain_and_idle(input int n);
        step(1'b0, 1'b1);
        repeat (n) step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ce", d_ce, e_ce);
            chk("in_ready", d_rdy, e_rdy);
            chk("busy", d_busy, e_busy);
            if (d_ce) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL ce_unexpected: got ce=1, expected no pending advance (t=%0t)", $time);
                end else begin
                    chk("advance_vec", d_vec, exp_q.pop_front());
                end
            end else begin
                chk("hold_vec", d_vec, e_vec);
            end
            if (d_fd) fd_seen++;
        end
    end

    // ---------------- stimulus ----------------
    int fd_base;
    initial begin
        bl = 0; sel2 = 1'b0;
        do_reset();

        // Back-to-back frame with hand-computed snapshots, then drain.
        fd_base = fd_seen;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0);
            if (i == 16) spot("k16", 5'b00001, 4'b0000, 20'h00000, 1'b0);
            if (i == 24) spot("k24", 5'b00011, 4'b0001, 20'h00008, 1'b0);
            if (i == 31) spot("k31", 5'b11111, 4'b1111, 20'h08CEF, 1'b1);
        end
        drain_and_idle(31);
        chk("frame_done_count_1frame", fd_seen - fd_base, 1);

        // Two frames; an early flush (ipos=8) must be ignored.
        fd_base = fd_seen;
        repeat (40) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (24) step(1'b1, 1'b0);
        drain_and_idle(31);
        chk("frame_done_count_2frames", fd_seen - fd_base, 2);

        // Stall five cycles at k=20.
        fd_base = fd_seen;
        repeat (20) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b0);
        drain_and_idle(31);
        chk("frame_done_count_stall", fd_seen - fd_base, 1);

        // Ignored flushes: in IDLE, at ipos=7, and together with in_valid at a boundary.
        fd_base = fd_seen;
        repeat (3) step(1'b0, 1'b1);
        repeat (7) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (25) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (31) step(1'b1, 1'b0);
        drain_and_idle(31);
        chk("frame_done_count_ignored_flush", fd_seen - fd_base, 2);

        // Mid-frame reset at k=40 aborts without frame_done; a new frame still times correctly.
        fd_base = fd_seen;
        repeat (40) step(1'b1, 1'b0);
        do_reset();
        chk("frame_done_count_abort", fd_seen - fd_base, 0);
        fd_base = fd_seen;
        repeat (32) step(1'b1, 1'b0);
        drain_and_idle(31);
        chk("frame_done_count_after_abort", fd_seen - fd_base, 1);

        // BF_LAT=2 instance: T_s = 16,26,32,36,39, first output at k=41, drain of 41.
        sel2 = 1'b1; bl = 2;
        do_reset();
        fd_base = fd_seen;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0);
            if (i == 26) spot("lat2_k26", 5'b00011, 4'b0001, 20'h0000A, 1'b0);
        end
        drain_and_idle(41);
        chk("frame_done_count_lat2", fd_seen - fd_base, 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
